vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_TOTAL, default 800, clocks per line.
REQ-002 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-003 Parameter H_BACK, default 48, back porch in clocks.
REQ-004 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-005 Parameter V_TOTAL, default 525, lines per frame.
REQ-006 Parameter V_SYNC, default 2; V_BACK, default 33; V_ACTIVE, default 480; all in lines.
REQ-007 Parameter LOCK_FRAMES, default 2, consecutive good frames required to lock.
REQ-008 board_clock  in  1  pixel clock, rising-edge active, one sample per pixel.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 hsync  in  1  incoming horizontal sync, active-low, asynchronous to board_clock.
REQ-011 vsync  in  1  incoming vertical sync, active-low, asynchronous to board_clock.
REQ-012 h_count  out  12  recovered horizontal position.
REQ-013 v_count  out  12  recovered line index.
REQ-014 x_val  out  10  active-area column; y_val  out  10  active-area row.
REQ-015 de  out  1  active-video qualifier.
REQ-016 locked  out  1  timing matches parameters.
REQ-017 frame_start  out  1  one-cycle pulse per detected vsync edge.
REQ-018 lock_lost  out  1  one-cycle pulse on LOCKED exit.

Function
REQ-019 The block SHALL pass each sync input through a 2-flop synchronizer, then a falling-edge detector; an input fall sampled at clock edge k is detected at edge k+2, and h_count/v_count react at edge k+3.
REQ-020 The block SHALL clear h_count on a detected hsync edge, otherwise increment it, saturating at 4095.
REQ-021 The block SHALL increment v_count on each hsync edge, clear it on a vsync edge, and saturate it at 4095; on simultaneous edges the clear wins and v_count = 0.
REQ-022 Line length SHALL be h_count+1 sampled at an hsync edge; frame length SHALL be v_count+1 sampled at a vsync edge.
REQ-023 The FSM SHALL have states SEARCH, MEASURE, LOCKED; SEARCH -> MEASURE on the first vsync edge, with good-frame counter = 0.
REQ-024 In MEASURE, a frame is good if every line length equals H_TOTAL and the frame length equals V_TOTAL; each good frame increments the counter, and any mismatch clears it.
REQ-025 MEASURE SHALL transition to LOCKED when the counter reaches LOCK_FRAMES, at the vsync edge closing that frame.
REQ-026 LOCKED SHALL transition to SEARCH on any line or frame length mismatch, or when h_count saturates (sync loss), and pulse lock_lost for one cycle.
REQ-027 locked SHALL be 1 exactly while in LOCKED.
REQ-028 de SHALL be 1 only when locked = 1, H_SYNC+H_BACK <= h_count < H_SYNC+H_BACK+H_ACTIVE, and V_SYNC+V_BACK <= v_count < V_SYNC+V_BACK+V_ACTIVE; de is combinational from registered counts.
REQ-029 x_val/y_val SHALL equal h_count-(H_SYNC+H_BACK) and v_count-(V_SYNC+V_BACK) when de = 1, and 0 otherwise.
REQ-030 frame_start SHALL pulse for one cycle on every vsync edge in all states.

Reset
REQ-031 rst_n low SHALL immediately force: all outputs 0, h_count = v_count = 0, synchronizer flops = 1 (idle-high), FSM = SEARCH, good-frame counter = 0.
REQ-032 Reset mid-frame SHALL discard all measurement; after release, lock requires a fresh SEARCH and LOCK_FRAMES good frames, with no lock_lost pulse.

Structure
REQ-033 Timing constants (640x480@60 values above) SHALL live in shared package vga_timing_pkg, also used by the VGA generator.
REQ-034 The 2-flop synchronizer plus falling-edge detector SHALL be sub-module vga_sync_edge, instantiated once each for hsync and vsync.

Verification
REQ-035 Drive the bench with the team's vga generator (800x525): locked rises at the 3rd vsync edge after reset (1 SEARCH + 2 good frames), and lock_lost never pulses.
REQ-036 In lock, at generator position h=144, v=35, expect de = 1 with x_val = 0, y_val = 0 three cycles later; at h=783, v=514, expect x_val = 639, y_val = 479; at h=784, expect de = 0.
REQ-037 While locked, shorten one line to 799 clocks: lock_lost pulses once at that hsync edge, locked = 0, and relock occurs after 2 further good frames.
REQ-038 Hold hsync high for 5000 clocks while locked: h_count sticks at 4095, and locked falls with a lock_lost pulse at saturation.
REQ-039 Deassert rst_n mid-frame while locked: outputs go to 0 asynchronously, and after release locked stays 0 until 3 vsync edges pass.
REQ-040 Apply coincident hsync/vsync falling edges: the next cycle shows v_count = 0 and h_count = 0, and frame_start pulses exactly once.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants plus the receiver's lock-state type.
// The VGA pattern generator takes its defaults from here as well.
package vga_timing_pkg;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BACK      = 48;
    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BACK      = 33;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_LOCK_FRAMES = 2;

    localparam int CNT_W  = 12;
    localparam int POS_W  = 10;
    localparam int GOOD_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // True when lo <= pos < lo+len.
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
        logic [31:0] p;
        p = {{(32-CNT_W){1'b0}}, pos};
        return (p >= 32'(lo)) && (p < 32'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer for an active-low sync input followed by a registered
// falling-edge detector; idles high so reset never produces a spurious edge.
module vga_sync_edge (
    input  logic board_clock,
    input  logic rst_n,
    input  logic sync,
    output logic fall
);

    logic meta;
    logic stable;
    logic stable_d;

    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            fall     <= 1'b0;
        end else begin
            meta     <= sync;
            stable   <= meta;
            stable_d <= stable;
            fall     <= stable_d & ~stable;
        end
    end

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers pixel/line position from incoming VGA syncs and declares lock once the
// measured line and frame lengths have matched the expected timing for LOCK_FRAMES frames.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic             board_clock,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic [POS_W-1:0] x_val,
    output logic [POS_W-1:0] y_val,
    output logic             de,
    output logic             locked,
    output logic             frame_start,
    output logic             lock_lost
);

    localparam int LEN_W = CNT_W + 1;
    localparam logic [LEN_W-1:0]  H_LEN  = LEN_W'(H_TOTAL);
    localparam logic [LEN_W-1:0]  V_LEN  = LEN_W'(V_TOTAL);
    localparam logic [GOOD_W:0]   LOCK_N = (GOOD_W + 1)'(LOCK_FRAMES);
    localparam logic [POS_W-1:0]  X_OFF  = POS_W'(H_SYNC + H_BACK);
    localparam logic [POS_W-1:0]  Y_OFF  = POS_W'(V_SYNC + V_BACK);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic hs_edge;
    logic vs_edge;

    vga_sync_edge u_hs_edge (
        .board_clock (board_clock),
        .rst_n       (rst_n),
        .sync        (hsync),
        .fall        (hs_edge)
    );

    vga_sync_edge u_vs_edge (
        .board_clock (board_clock),
        .rst_n       (rst_n),
        .sync        (vsync),
        .fall        (vs_edge)
    );

    // Position counters; a vsync clear beats the hsync increment on coincident edges.
    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= hs_edge ? '0 : sat_inc(h_count);
            if (vs_edge) begin
                v_count <= '0;
            end else if (hs_edge) begin
                v_count <= sat_inc(v_count);
            end
        end
    end

    logic [LEN_W-1:0] line_len;
    logic [LEN_W-1:0] frame_len;
    logic             line_bad;
    logic             frame_bad;
    logic             h_sat_next;

    assign line_len   = {1'b0, h_count} + 1'b1;
    assign frame_len  = {1'b0, v_count} + 1'b1;
    assign line_bad   = hs_edge && (line_len != H_LEN);
    assign frame_bad  = vs_edge && (frame_len != V_LEN);
    assign h_sat_next = !hs_edge && (h_count >= CNT_MAX - 1'b1);

    lock_state_t       state;
    lock_state_t       state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W:0]   good_next;
    logic              frame_ok;
    logic              frame_good;
    logic              lock_reached;
    logic              lose;

    // The line closing at a vsync edge still belongs to the frame being judged.
    assign frame_good   = frame_ok && !line_bad && !frame_bad;
    assign good_next    = {1'b0, good_cnt} + 1'b1;
    assign lock_reached = good_next >= LOCK_N;

    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SEARCH: begin
                if (vs_edge) state_next = MEASURE;
            end
            MEASURE: begin
                if (vs_edge && frame_good && lock_reached) state_next = LOCKED;
            end
            LOCKED: begin
                if (line_bad || frame_bad || h_sat_next) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        lose   = 1'b0;
        if (state == LOCKED) begin
            locked = 1'b1;
            lose   = (state_next != LOCKED);
        end
    end

    // Good-frame bookkeeping only runs while measuring; any other state restarts it.
    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            frame_ok <= 1'b1;
        end else if (state != MEASURE) begin
            good_cnt <= '0;
            frame_ok <= 1'b1;
        end else if (vs_edge) begin
            good_cnt <= frame_good ? good_next[GOOD_W-1:0] : '0;
            frame_ok <= 1'b1;
        end else if (line_bad) begin
            good_cnt <= '0;
            frame_ok <= 1'b0;
        end
    end

    always_ff @(posedge board_clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            frame_start <= vs_edge;
            lock_lost   <= lose;
        end
    end

    // Offsets are taken modulo 2^POS_W; inside the active window they are exact.
    assign de    = locked
                 && in_window(h_count, H_SYNC + H_BACK, H_ACTIVE)
                 && in_window(v_count, V_SYNC + V_BACK, V_ACTIVE);
    assign x_val = de ? (h_count[POS_W-1:0] - X_OFF) : '0;
    assign y_val = de ? (v_count[POS_W-1:0] - Y_OFF) : '0;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: a scaled-down VGA generator, a behavioural reference model
// checked every cycle, a window-position table and directed lock/loss/reset sequences.
module tb_vga_sync_rx;

    localparam int HT = 40, HS = 4, HB = 6, HA = 24;
    localparam int VT = 20, VS = 2, VB = 3, VA = 12;
    localparam int LF = 2;
    localparam int FRAME = HT * VT;
    localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

    logic        board_clock = 1'b0;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic [9:0]  x_val;
    logic [9:0]  y_val;
    logic        de;
    logic        locked;
    logic        frame_start;
    logic        lock_lost;

    vga_sync_rx #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .board_clock (board_clock),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .h_count     (h_count),
        .v_count     (v_count),
        .x_val       (x_val),
        .y_val       (y_val),
        .de          (de),
        .locked      (locked),
        .frame_start (frame_start),
        .lock_lost   (lock_lost)
    );

    always #5 board_clock = ~board_clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic hh[4];            // hsync samples at edges t-1 .. t-4
    logic vh[4];
    int   m_h, m_v, m_mode, m_good;
    int   m_lines[$];
    int   m_fs, m_ll;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hh[i] = 1'b1;
            vh[i] = 1'b1;
        end
        m_h = 0; m_v = 0; m_mode = M_SEARCH; m_good = 0;
        m_lines.delete();
        m_fs = 0; m_ll = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs);
        logic hdet, vdet, ok;
        int   line_len, frame_len, nh, nv, lost;
        // A fall first sampled at edge k moves the counters at edge k+3.
        hdet = !hh[2] && hh[3];
        vdet = !vh[2] && vh[3];
        line_len  = m_h + 1;
        frame_len = m_v + 1;
        nh = hdet ? 0 : ((m_h >= 4095) ? 4095 : m_h + 1);
        nv = vdet ? 0 : (hdet ? ((m_v >= 4095) ? 4095 : m_v + 1) : m_v);
        lost = 0;
        case (m_mode)
            M_SEARCH: begin
                if (vdet) begin
                    m_mode = M_MEASURE;
                    m_good = 0;
                    m_lines.delete();
                end
            end
            M_MEASURE: begin
                if (hdet) m_lines.push_back(line_len);
                if (vdet) begin
                    ok = (frame_len == VT);
                    foreach (m_lines[i]) if (m_lines[i] != HT) ok = 1'b0;
                    m_lines.delete();
                    m_good = ok ? m_good + 1 : 0;
                    if (m_good >= LF) m_mode = M_LOCKED;
                end
            end
            default: begin
                if ((hdet && line_len != HT) || (vdet && frame_len != VT) || nh == 4095) begin
                    m_mode = M_SEARCH;
                    lost = 1;
                end
            end
        endcase
        m_h = nh; m_v = nv;
        m_fs = int'(vdet); m_ll = lost;
        for (int i = 3; i > 0; i--) begin
            hh[i] = hh[i-1];
            vh[i] = vh[i-1];
        end
        hh[0] = hs;
        vh[0] = vs;
    endtask

    task automatic compare_all();
        int e_lock, e_de, e_x, e_y;
        e_lock = (m_mode == M_LOCKED) ? 1 : 0;
        e_de   = (e_lock == 1 && m_h >= HS + HB && m_h < HS + HB + HA &&
                  m_v >= VS + VB && m_v < VS + VB + VA) ? 1 : 0;
        e_x    = e_de ? m_h - (HS + HB) : 0;
        e_y    = e_de ? m_v - (VS + VB) : 0;
        chk("h_count", int'(h_count), m_h);
        chk("v_count", int'(v_count), m_v);
        chk("locked", int'(locked), e_lock);
        chk("de", int'(de), e_de);
        chk("x_val", int'(x_val), e_x);
        chk("y_val", int'(y_val), e_y);
        chk("frame_start", int'(frame_start), m_fs);
        chk("lock_lost", int'(lock_lost), m_ll);
    endtask

    // ---------------- stimulus ----------------
    int fs_seen = 0;
    int ll_seen = 0;

    task automatic tick(input logic hs, input logic vs);
        hsync = hs;
        vsync = vs;
        @(posedge board_clock);
        if (rst_n) model_step(hs, vs);
        else       model_reset();
        @(negedge board_clock);
        compare_all();
        if (frame_start) fs_seen++;
        if (lock_lost)   ll_seen++;
    endtask

    int   gh = 0, gv = 7, cur_len = HT;
    logic force_high = 1'b0;

    task automatic gen_clock();
        logic hs, vs;
        hs = force_high ? 1'b1 : !(gh < HS);
        vs = force_high ? 1'b1 : !(gv < VS);
        tick(hs, vs);
        gh++;
        if (gh >= cur_len) begin
            gh = 0;
            cur_len = HT;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(gh == h && gv == v) && n < 2 * FRAME) begin
            gen_clock();
            n++;
        end
        chk("reach_position", int'(gh == h && gv == v), 1);
    endtask

    task automatic run_until_locked(input string name, input int budget);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            gen_clock();
            n++;
        end
        chk(name, int'(locked), 1);
    endtask

    typedef struct {
        int h;
        int v;
        int de;
        int x;
        int y;
    } win_vec_t;

    win_vec_t wv[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs0, ll0, n, sat_h;

        wv[0] = '{h: 9,  v: 5,  de: 0, x: 0,  y: 0};
        wv[1] = '{h: 10, v: 5,  de: 1, x: 0,  y: 0};
        wv[2] = '{h: 20, v: 10, de: 1, x: 10, y: 5};
        wv[3] = '{h: 33, v: 16, de: 1, x: 23, y: 11};
        wv[4] = '{h: 34, v: 16, de: 0, x: 0,  y: 0};
        wv[5] = '{h: 10, v: 17, de: 0, x: 0,  y: 0};
        wv[6] = '{h: 10, v: 4,  de: 0, x: 0,  y: 0};

        rst_n = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        model_reset();
        @(negedge board_clock);
        repeat (3) gen_clock();
        chk("rst_locked", int'(locked), 0);
        chk("rst_h_count", int'(h_count), 0);

        // Acquisition: one SEARCH frame, then LF good frames.
        rst_n = 1'b1;
        gh = 0; gv = 7;
        fs_seen = 0; ll_seen = 0;
        run_until_locked("acq_lock", 6 * FRAME);
        chk("acq_lock_on_3rd_vsync", fs_seen, 3);
        chk("acq_lock_with_frame_start", int'(frame_start), 1);
        chk("acq_no_lock_lost", ll_seen, 0);

        // Active-window boundaries, sampled three cycles after the generator position.
        foreach (wv[i]) begin
            run_to(wv[i].h, wv[i].v);
            repeat (4) gen_clock();
            chk("win_locked", int'(locked), 1);
            chk("win_de", int'(de), wv[i].de);
            chk("win_x", int'(x_val), wv[i].x);
            chk("win_y", int'(y_val), wv[i].y);
        end

        // Coincident hsync/vsync falls at frame start.
        run_to(0, 0);
        n = 0;
        while (!frame_start && n < 10) begin
            gen_clock();
            n++;
        end
        chk("coin_frame_start", int'(frame_start), 1);
        chk("coin_h_zero", int'(h_count), 0);
        chk("coin_v_zero", int'(v_count), 0);
        fs0 = fs_seen;
        gen_clock();
        chk("coin_pulse_width", int'(frame_start), 0);
        repeat (FRAME - 1) gen_clock();
        chk("coin_one_per_frame", fs_seen - fs0, 1);

        // One short line while locked.
        run_to(0, 8);
        ll0 = ll_seen;
        cur_len = HT - 1;
        n = 0;
        while (!lock_lost && n < 2 * HT) begin
            gen_clock();
            n++;
        end
        chk("short_lost_pulse", int'(lock_lost), 1);
        chk("short_locked_low", int'(locked), 0);
        chk("short_at_hsync", int'(h_count), 0);
        fs0 = fs_seen;
        run_until_locked("short_relock", 6 * FRAME);
        chk("short_relock_vsyncs", fs_seen - fs0, 3);
        chk("short_single_lost", ll_seen - ll0, 1);

        // Syncs stuck high until h_count saturates.
        run_to(20, 10);
        ll0 = ll_seen;
        sat_h = -1;
        force_high = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            gen_clock();
            if (lock_lost) sat_h = int'(h_count);
        end
        force_high = 1'b0;
        chk("hold_h_stuck", int'(h_count), 4095);
        chk("hold_lost_at_sat", sat_h, 4095);
        chk("hold_single_lost", ll_seen - ll0, 1);
        chk("hold_locked_low", int'(locked), 0);
        run_until_locked("hold_relock", 6 * FRAME);

        // Asynchronous reset in the middle of a locked frame.
        run_to(15, 9);
        chk("pre_reset_locked", int'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_h", int'(h_count), 0);
        chk("async_rst_v", int'(v_count), 0);
        chk("async_rst_de", int'(de), 0);
        chk("async_rst_x", int'(x_val), 0);
        chk("async_rst_lost", int'(lock_lost), 0);
        model_reset();
        repeat (2) gen_clock();
        rst_n = 1'b1;
        fs0 = fs_seen;
        ll0 = ll_seen;
        run_until_locked("reset_relock", 6 * FRAME);
        chk("reset_relock_vsyncs", fs_seen - fs0, 3);
        chk("reset_no_lost", ll_seen - ll0, 0);

        // Random glitchy syncs against the model.
        for (int i = 0; i < 1500; i++) begin
            tick(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 49) != 0));
        end

        // Generator with occasional line-length jitter.
        gh = 0; gv = 0; cur_len = HT;
        for (int ln = 0; ln < 8 * VT; ln++) begin
            case ($urandom_range(0, 29))
                0:       cur_len = HT - 1;
                1:       cur_len = HT + 1;
                default: cur_len = HT;
            endcase
            n = cur_len;
            repeat (n) gen_clock();
        end

        run_until_locked("final_lock", 6 * FRAME);
        repeat (FRAME) gen_clock();
        chk("final_still_locked", int'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
